sa_skew_feeder: RTL and testbench
=================================

SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (lanes per operand).
REQ-002 SHALL have parameter W, default 16, meaning operand width per lane.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a tile.
REQ-006 SHALL have port k_len  input  8  number of operand vectors in the tile, sampled on accepted start.
REQ-007 SHALL have port in_valid  input  1  in_a/in_b hold a valid vector.
REQ-008 SHALL have port in_ready  output  1  feeder accepts a vector this cycle.
REQ-009 SHALL have port in_a  input  N*W  row-operand vector; lane i at bits [i*W +: W].
REQ-010 SHALL have port in_b  input  N*W  column-operand vector; same packing.
REQ-011 SHALL have port arr_a  output  N*W  skewed row operands to array west edge.
REQ-012 SHALL have port arr_b  output  N*W  skewed column operands to array north edge.
REQ-013 SHALL have port arr_en  output  1  array-wide enable.
REQ-014 SHALL have port arr_clr  output  1  array accumulator clear; asserted only while arr_en=0.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse; array accumulators hold final tile results.

Function
REQ-017 SHALL implement states IDLE, CLEAR, STREAM, FLUSH, DONE.
REQ-018 IDLE: start=1 with k_len!=0 -> CLEAR and latches k_len; start with k_len=0 is ignored and the block stays in IDLE.
REQ-019 CLEAR: lasts exactly 1 cycle with arr_clr=1 and arr_en=0, then -> STREAM.
REQ-020 STREAM: in_ready=1; accept = in_valid & in_ready; arr_en = accept; after k_len accepts -> FLUSH on the same edge as the last accept.
REQ-021 STREAM with in_valid=0: arr_en=0, skew registers hold, array frozen; no timeout.
REQ-022 FLUSH: in_ready=0, arr_en=1 for exactly 2N-1 cycles with zero injected on all lanes, then -> DONE.
REQ-023 DONE: done=1, arr_en=0 for 1 cycle, then -> IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 Skew: lane i of arr_a/arr_b equals lane i of the accepted vector delayed by i enable-steps; lane 0 is a combinational pass-through of the input when accepted, zero otherwise.
REQ-026 Skew shift registers (i registers for lane i) SHALL advance only on cycles with arr_en=1; the input to the shift chain is the accepted lane value in STREAM and zero in FLUSH.
REQ-027 arr_a/arr_b SHALL be zero whenever state is IDLE, CLEAR, or DONE.
REQ-028 Accept counter and flush counter SHALL be 8 bits; no wrap is possible because k_len is at most 255.
REQ-029 Total cycles from accepted start to done with in_valid held at 1 SHALL be 1 + k_len + (2N-1), with done asserted on the following cycle.

Reset
REQ-030 RST=1 SHALL immediately force IDLE and zero all skew registers and counters; outputs become in_ready=0, arr_en=0, arr_clr=0, busy=0, done=0, arr_a=0, arr_b=0.
REQ-031 RST asserted mid-tile SHALL abort the tile without a done pulse; the next tile SHALL begin with CLEAR.
REQ-032 Deassertion of RST SHALL take effect at the next CLK edge; the first start is accepted no earlier than that edge.

Verification
REQ-033 N=4, k_len=1, in_a lanes={1,2,3,4}, in_valid held -> arr_a lanes 0..3 show 1,2,3,4 on enable-steps 0,1,2,3; done occurs 9 cycles after start.
REQ-034 k_len=4, identity A, B lanes=vector k+1 on step k, in_valid held -> arr_en high for 11 consecutive cycles; downstream 4x4 hPE model C equals B.
REQ-035 k_len=3 with in_valid low for 2 cycles after the first accept -> arr_en low and arr_a/arr_b registers frozen in the gap; final C matches the unstalled run.
REQ-036 RST pulsed during FLUSH cycle 3 -> all outputs 0 and no done; a subsequent start with k_len=2 -> arr_clr pulse, then normal completion.
REQ-037 start with k_len=0 -> busy stays 0 and no outputs toggle; start asserted during STREAM -> ignored and the tile length is unchanged.
REQ-038 arr_clr and arr_en SHALL never be high in the same cycle (assertion checked throughout every test).

Source files
------------

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder
// Feeds row (A) and column (B) operand vectors into the west and north edges
// of an N x N systolic array. Each lane is delayed by its index (counted in
// enable-steps) so that operands meet on the array diagonals. A tile runs
// through CLEAR (accumulator clear), STREAM (k_len accepted vectors),
// FLUSH (2N-1 zero-injection steps) and DONE (one-cycle done pulse).
//
// Ports
//   CLK, RST       clock (rising edge), asynchronous active-high reset
//   start, k_len   tile request and tile length (sampled when start is accepted)
//   in_valid       in_a/in_b carry a vector
//   in_ready       feeder accepts a vector this cycle (STREAM only)
//   in_a, in_b     operand vectors, lane i at bits [i*W +: W]
//   arr_a, arr_b   skewed operands to the array west / north edges
//   arr_en         array-wide enable (one enable-step per high cycle)
//   arr_clr        array accumulator clear
//   busy           high whenever a tile is in progress
//   done           one-cycle pulse once the array holds the final results
module sa_skew_feeder #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [7:0]   k_len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic [N*W-1:0] arr_a,
  output logic [N*W-1:0] arr_b,
  output logic         arr_en,
  output logic         arr_clr,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Last flush step index: the flush phase spans 2N-1 enable-steps, enough
  // for the last accepted vector to cross the far corner of the array.
  localparam logic [7:0] FLUSH_LAST = 8'(2 * N - 2);

  state_t       state;
  state_t       state_nx;
  logic [7:0]   k_reg;
  logic [7:0]   acc_cnt;
  logic [7:0]   flush_cnt;
  logic         accept;
  logic         lane_vis;
  logic [N*W-1:0] feed_a;
  logic [N*W-1:0] feed_b;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // k_reg only loads on an accepted start, so a start seen while busy
  // cannot change the length of the running tile.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_reg     <= 8'd0;
      acc_cnt   <= 8'd0;
      flush_cnt <= 8'd0;
    end else begin
      if (state == IDLE && start && k_len != 8'd0) begin
        k_reg <= k_len;
      end
      if (state == CLEAR) begin
        acc_cnt <= 8'd0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + 8'd1;
      end
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 8'd1;
      end else begin
        flush_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    arr_en   = 1'b0;
    arr_clr  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start && k_len != 8'd0) begin
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        arr_clr  = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        arr_en   = in_valid;
        if (in_valid && acc_cnt == k_reg - 8'd1) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        arr_en = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign lane_vis = (state == STREAM) || (state == FLUSH);

  // Shift-chain input: the accepted vector in STREAM, zero otherwise.
  // In FLUSH accept is low, so zeros are injected on every lane.
  assign feed_a = accept ? in_a : '0;
  assign feed_b = accept ? in_b : '0;

  // Lane 0 has no delay.
  assign arr_a[W-1:0] = feed_a[W-1:0];
  assign arr_b[W-1:0] = feed_b[W-1:0];

  // Lane i owns i registers that advance only on enable-steps, so a stalled
  // STREAM cycle freezes the whole skew front together with the array.
  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [W-1:0] sr_a [i];
    logic [W-1:0] sr_b [i];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int j = 0; j < i; j++) begin
          sr_a[j] <= '0;
          sr_b[j] <= '0;
        end
      end else if (arr_en) begin
        sr_a[0] <= feed_a[i*W +: W];
        sr_b[0] <= feed_b[i*W +: W];
        for (int j = 1; j < i; j++) begin
          sr_a[j] <= sr_a[j-1];
          sr_b[j] <= sr_b[j-1];
        end
      end
    end

    assign arr_a[i*W +: W] = lane_vis ? sr_a[i-1] : '0;
    assign arr_b[i*W +: W] = lane_vis ? sr_b[i-1] : '0;
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder
// Scoreboard bench for sa_skew_feeder. For each tile the expected sequence
// of enabled array-edge vectors (operand t-i on lane i at step t) and the
// expected matrix product C = sum_k a_k (outer) b_k are queued up front.
// A negedge monitor pops one edge vector per arr_en cycle, accumulates a
// downstream output-stationary PE grid from the observed edges, and compares
// the grid against the queued product when done pulses.
module tb_sa_skew_feeder;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
  } step_t;

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic [7:0]     k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [N*W-1:0] arr_a;
  logic [N*W-1:0] arr_b;
  logic           arr_en;
  logic           arr_clr;
  logic           busy;
  logic           done;

  int checks = 0;
  int fails  = 0;

  step_t           exp_q[$];
  longint unsigned c_q[$];
  step_t           hist[$];
  int              en_run   = 0;
  int              last_run = 0;

  logic [W-1:0] vec_a [256][N];
  logic [W-1:0] vec_b [256][N];

  always #5 CLK = ~CLK;

  sa_skew_feeder #(.N(N), .W(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .arr_en   (arr_en),
    .arr_clr  (arr_clr),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack_vec(input int idx, input bit col);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = col ? vec_b[idx][i] : vec_a[idx][i];
    end
    return r;
  endfunction

  // Reference: edge vector at step t carries operand (t-i) on lane i, zero
  // outside the tile; the tile result is the sum of outer products.
  task automatic push_expected(input int k);
    step_t           e;
    logic [N*W-1:0]  ta, tb;
    longint unsigned acc;
    for (int t = 0; t < k + 2*N - 1; t++) begin
      ta = '0;
      tb = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < k) begin
          ta[i*W +: W] = vec_a[t-i][i];
          tb[i*W +: W] = vec_b[t-i][i];
        end
      end
      e.a = ta;
      e.b = tb;
      exp_q.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int s = 0; s < k; s++) begin
          acc += 64'(vec_a[s][i]) * 64'(vec_b[s][j]);
        end
        c_q.push_back(acc);
      end
    end
  endtask

  // Monitor: checks every cycle, pops the scoreboard on each enable-step,
  // and evaluates a downstream PE grid on done.
  always @(negedge CLK) begin
    step_t           e;
    logic [N*W-1:0]  fa, fb, ha, hb;
    longint unsigned acc;
    check_output("clr_en_exclusive", {63'b0, arr_clr & arr_en}, 64'd0);
    if (!busy || arr_clr || done) begin
      check_output("edge_a_zero", arr_a, 64'd0);
      check_output("edge_b_zero", arr_b, 64'd0);
    end
    if (arr_clr) begin
      hist.delete();
    end
    if (in_ready && !in_valid && exp_q.size() != 0) begin
      fa = exp_q[0].a;
      fb = exp_q[0].b;
      fa[W-1:0] = '0;
      fb[W-1:0] = '0;
      check_output("stall_freeze_a", arr_a, fa);
      check_output("stall_freeze_b", arr_b, fb);
    end
    if (arr_en) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_enable", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("step_arr_a", arr_a, e.a);
        check_output("step_arr_b", arr_b, e.b);
      end
      e.a = arr_a;
      e.b = arr_b;
      hist.push_back(e);
      en_run++;
    end else if (en_run != 0) begin
      last_run = en_run;
      en_run   = 0;
    end
    if (done) begin
      // PE(i,j) sees west lane i delayed by j steps and north lane j by i.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc = 0;
          for (int t = 0; t < hist.size(); t++) begin
            if (t >= i && t >= j) begin
              ha = hist[t-j].a;
              hb = hist[t-i].b;
              acc += 64'(ha[i*W +: W]) * 64'(hb[j*W +: W]);
            end
          end
          if (c_q.size() == 0) begin
            check_output("c_missing", 64'd1, 64'd0);
          end else begin
            check_output("c_result", acc, c_q.pop_front());
          end
        end
      end
    end
  end

  // Runs one tile. stall_pct < 0 inserts exactly two stalls after the first
  // accept; poke issues a start with a different length mid-tile.
  task automatic apply_stimulus(input int k, input int stall_pct, input bit poke);
    int cycles;
    int stalls;
    int idx;
    bit rdy;
    push_expected(k);
    @(posedge CLK); #1;
    start = 1'b1;
    k_len = 8'(k);
    @(posedge CLK); #1;
    start  = 1'b0;
    k_len  = 8'($urandom);
    cycles = 0;
    stalls = 0;
    idx    = 0;
    check_output("clear_pulse", {62'b0, arr_clr, busy}, 64'd3);
    while (idx < k && cycles < 4000) begin
      if (stall_pct < 0) begin
        in_valid = !(idx == 1 && stalls < 2);
      end else begin
        in_valid = ($urandom_range(99) >= stall_pct);
      end
      in_a = pack_vec(idx, 1'b0);
      in_b = pack_vec(idx, 1'b1);
      if (poke && cycles == 3) begin
        start = 1'b1;
        k_len = 8'(k + 5);
      end
      rdy = in_ready;
      if (rdy && !in_valid) stalls++;
      @(posedge CLK); #1;
      cycles++;
      start = 1'b0;
      if (rdy && in_valid) idx++;
    end
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    while (!done && cycles < 4000) begin
      @(posedge CLK); #1;
      cycles++;
    end
    if (!done) begin
      check_output("done_timeout", 64'd0, 64'd1);
    end else begin
      check_output("latency", 64'(cycles), 64'(k + 2*N + stalls));
    end
    @(posedge CLK); #1;
    check_output("done_one_cycle", {62'b0, done, busy}, 64'd0);
    if (stall_pct == 0) begin
      check_output("enable_run", 64'(last_run), 64'(k + 2*N - 1));
    end
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_random(input int k);
    for (int s = 0; s < k; s++) begin
      for (int i = 0; i < N; i++) begin
        vec_a[s][i] = W'($urandom);
        vec_b[s][i] = W'($urandom);
      end
    end
  endtask

  task automatic abort_in_flush();
    int cycles;
    int idx;
    fill_random(3);
    push_expected(3);
    @(posedge CLK); #1;
    start = 1'b1;
    k_len = 8'd3;
    @(posedge CLK); #1;
    start  = 1'b0;
    cycles = 0;
    idx    = 0;
    while (idx < 3 && cycles < 100) begin
      in_valid = 1'b1;
      in_a = pack_vec(idx, 1'b0);
      in_b = pack_vec(idx, 1'b1);
      if (in_ready) idx++;
      @(posedge CLK); #1;
      cycles++;
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    check_output("abort_outputs", {in_ready, arr_en, arr_clr, busy, done, arr_a[58:0]} | 64'(arr_b != 0), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      check_output("abort_no_done", {63'b0, done}, 64'd0);
    end
    exp_q.delete();
    c_q.delete();
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    start    = 1'b0;
    k_len    = 8'd0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #1;
    check_output("reset_outputs", {in_ready, arr_en, arr_clr, busy, done}, 64'd0);
    check_output("reset_edges", arr_a | arr_b, 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("[TB] single vector, lanes 1..4");
    for (int i = 0; i < N; i++) begin
      vec_a[0][i] = W'(i + 1);
      vec_b[0][i] = W'($urandom);
    end
    apply_stimulus(1, 0, 1'b0);

    $display("[TB] identity A, k_len=4");
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N; i++) begin
        vec_a[s][i] = (s == i) ? W'(1) : W'(0);
        vec_b[s][i] = W'(s + 1);
      end
    end
    apply_stimulus(4, 0, 1'b0);

    $display("[TB] k_len=3 unstalled then with two-cycle gap");
    fill_random(3);
    apply_stimulus(3, 0, 1'b0);
    apply_stimulus(3, -1, 1'b0);

    $display("[TB] reset during flush, then k_len=2");
    abort_in_flush();
    fill_random(2);
    apply_stimulus(2, 0, 1'b0);

    $display("[TB] start with k_len=0 ignored");
    @(posedge CLK); #1;
    start = 1'b1;
    k_len = 8'd0;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_output("zero_len_idle", {in_ready, arr_en, arr_clr, busy, done}, 64'd0);
      @(posedge CLK); #1;
    end

    $display("[TB] start while busy ignored");
    fill_random(5);
    apply_stimulus(5, 0, 1'b1);

    $display("[TB] random tiles with stalls");
    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(20, 1);
      fill_random(k);
      apply_stimulus(k, 30, 1'b0);
    end

    $display("[TB] maximum tile length");
    fill_random(255);
    apply_stimulus(255, 0, 1'b0);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
